// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad event path: key code width, named codes,
// default debounce window and the debounce state encoding.
package keypad_pkg;

  localparam int KEY_W                 = 4;
  localparam int STABLE_CYCLES_DEFAULT = 2_000_000;

  // E and F are reserved by the consumer as control keys.
  typedef enum logic [KEY_W-1:0] {
    KEY_0 = 4'h0, KEY_1 = 4'h1, KEY_2 = 4'h2, KEY_3 = 4'h3,
    KEY_4 = 4'h4, KEY_5 = 4'h5, KEY_6 = 4'h6, KEY_7 = 4'h7,
    KEY_8 = 4'h8, KEY_9 = 4'h9, KEY_A = 4'hA, KEY_B = 4'hB,
    KEY_C = 4'hC, KEY_D = 4'hD, KEY_E = 4'hE, KEY_F = 4'hF
  } key_code_e;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } db_state_e;

endpackage

// File: rtl/keypad_event_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always visible on data_out,
// and a push into a full FIFO succeeds only when a pop frees a slot that cycle.
module keypad_event_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data_out,
  output logic [PTR_W:0]   count,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             wr_en, rd_en;

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign valid    = (count_q != '0);
  assign count    = count_q;
  assign data_out = valid ? mem[rd_ptr_q] : '0;

  assign rd_en = pop && valid;
  assign wr_en = push && (!full || rd_en);

  // NOTE: storage is deliberately not reset; data_out is masked while empty,
  // so stale or unknown contents can never reach the consumer.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/keypad_key_fifo.sv
// Debounces the keypad decoder's pressed level and code, emits one event per
// physical press into a show-ahead FIFO, and flags dropped events.
module keypad_key_fifo
  import keypad_pkg::*;
#(
  parameter  int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter  int FIFO_DEPTH    = 4,
  localparam int CNT_W         = ($clog2(STABLE_CYCLES) > 0) ? $clog2(STABLE_CYCLES) : 1,
  localparam int PTR_W         = $clog2(FIFO_DEPTH)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [KEY_W-1:0] key_code,
  input  logic             key_pressed,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_data,
  input  logic             key_ready,
  output logic [PTR_W:0]   fifo_count,
  output logic             overflow,
  input  logic             overflow_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic             push, pop, fifo_full, overflow_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
          cand_d  = key_code;
        end
      end
      PRESS_WAIT: begin
        // Any release or code change restarts the window from IDLE.
        if (!key_pressed || key_code != cand_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          push    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!key_pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (key_pressed) begin
          state_d = HELD;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop = key_valid && key_ready;

  keypad_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_W)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (push),
    .data_in   (cand_q),
    .pop       (pop),
    .valid     (key_valid),
    .data_out  (key_data),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  // Setting wins over a simultaneous clear so a drop is never lost.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      overflow_q <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow_q <= 1'b1;
    end else if (overflow_clr) begin
      overflow_q <= 1'b0;
    end
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_keypad_key_fifo.sv
// Directed bench for keypad_key_fifo with a 16-cycle debounce window and a
// 4-entry FIFO; inputs change and outputs are sampled on the falling edge.
module tb_keypad_key_fifo;
  import keypad_pkg::*;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] key_code = '0;
  logic       key_pressed = 1'b0;
  logic       key_valid;
  logic [3:0] key_data;
  logic       key_ready = 1'b0;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       overflow_clr = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 sys_clk = ~sys_clk;

  keypad_key_fifo #(
    .STABLE_CYCLES (16),
    .FIFO_DEPTH    (4)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .key_code     (key_code),
    .key_pressed  (key_pressed),
    .key_valid    (key_valid),
    .key_data     (key_data),
    .key_ready    (key_ready),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Hold a key long enough to be accepted, then release it long enough to
  // return the debouncer to IDLE.
  task automatic press(input logic [3:0] code);
    key_code    = code;
    key_pressed = 1'b1;
    step(20);
    key_pressed = 1'b0;
    step(20);
  endtask

  task automatic pop_one();
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    step(2);
    check("rst_valid", key_valid, 0);
    check("rst_data", key_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    sys_rst_n = 1'b1;
    step(2);

    // Clean press: push lands on the 17th rising edge after the rise
    key_code    = KEY_5;
    key_pressed = 1'b1;
    step(16);
    check("clean_not_early", key_valid, 0);
    step(1);
    check("clean_valid", key_valid, 1);
    check("clean_data", key_data, 5);
    check("clean_count", fifo_count, 1);
    step(23);
    key_pressed = 1'b0;
    step(20);
    check("clean_single_event", fifo_count, 1);
    pop_one();
    check("clean_popped", fifo_count, 0);
    check("clean_empty_valid", key_valid, 0);

    // Bounce: 5-cycle toggling never survives the window
    key_code = KEY_9;
    for (int i = 0; i < 12; i++) begin
      key_pressed = (i % 2 == 0);
      step(5);
    end
    check("bounce_no_event", fifo_count, 0);
    key_pressed = 1'b1;
    step(17);
    check("bounce_count", fifo_count, 1);
    check("bounce_data", key_data, 9);
    step(3);
    key_pressed = 1'b0;
    step(20);
    check("bounce_single_event", fifo_count, 1);
    pop_one();

    // Code change during PRESS_WAIT restarts the window with the new code
    key_code    = KEY_3;
    key_pressed = 1'b1;
    step(10);
    key_code = KEY_7;
    step(16);
    check("chg_not_early", fifo_count, 0);
    step(4);
    check("chg_count", fifo_count, 1);
    check("chg_data", key_data, 7);
    key_pressed = 1'b0;
    step(20);
    check("chg_single_event", fifo_count, 1);
    pop_one();
    check("chg_popped", fifo_count, 0);

    // Overflow: fifth press dropped; a clear on the same cycle loses to the set
    press(KEY_1);
    press(KEY_2);
    press(KEY_3);
    press(KEY_4);
    check("full_count", fifo_count, 4);
    check("full_no_overflow", overflow, 0);
    key_code    = KEY_6;
    key_pressed = 1'b1;
    step(16);
    overflow_clr = 1'b1;
    step(1);
    overflow_clr = 1'b0;
    check("ovf_set_beats_clr", overflow, 1);
    step(3);
    key_pressed = 1'b0;
    step(20);
    check("ovf_count", fifo_count, 4);
    check("ovf_head", key_data, 1);
    key_ready = 1'b1;
    check("ovf_pop0", key_data, 1);
    step(1);
    check("ovf_pop1", key_data, 2);
    step(1);
    check("ovf_pop2", key_data, 3);
    step(1);
    check("ovf_pop3", key_data, 4);
    step(1);
    key_ready = 1'b0;
    check("ovf_drained", fifo_count, 0);
    check("ovf_sticky", overflow, 1);
    overflow_clr = 1'b1;
    step(1);
    overflow_clr = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Push and pop on the same cycle while full: nothing is dropped
    press(KEY_1);
    press(KEY_2);
    press(KEY_3);
    press(KEY_4);
    key_code    = KEY_A;
    key_pressed = 1'b1;
    step(16);
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    check("pp_count", fifo_count, 4);
    check("pp_no_overflow", overflow, 0);
    check("pp_head", key_data, 2);
    key_pressed = 1'b0;
    step(20);
    pop_one();
    check("pp_next3", key_data, 3);
    pop_one();
    check("pp_next4", key_data, 4);
    pop_one();
    check("pp_tail", key_data, 4'hA);
    pop_one();
    check("pp_drained", fifo_count, 0);

    // Asynchronous reset while HELD with two entries queued
    press(KEY_1);
    key_code    = KEY_2;
    key_pressed = 1'b1;
    step(20);
    check("rm_pre_count", fifo_count, 2);
    #2 sys_rst_n = 1'b0;
    #1;
    check("rm_valid", key_valid, 0);
    check("rm_data", key_data, 0);
    check("rm_count", fifo_count, 0);
    check("rm_overflow", overflow, 0);
    step(2);
    sys_rst_n = 1'b1;
    step(16);
    check("rm_not_early", fifo_count, 0);
    step(1);
    check("rm_event_count", fifo_count, 1);
    check("rm_event_data", key_data, 2);
    key_pressed = 1'b0;
    step(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
